// File: rtl/serial_reg_loader.sv
// serial_reg_loader
//   Serial-to-parallel write front end for the 64x32 register bank.
//   A frame is: start bit (0), ADDR_W address bits MSB first, DATA_W data
//   bits MSB first, an optional even-parity bit, then a stop bit (1).
//   A good frame drives load/reg_select/data_in to the bank for one cycle.
//   A bad frame produces a one-cycle frame_err and leaves the bank untouched.
//
//   Optional feature macro: SERIAL_REG_LOADER_PARITY_EN
//     defined   -> a parity bit follows the data. The XOR of all address,
//                  data and parity bits must be 0.
//     undefined -> the stop bit directly follows the data (40-bit frame).
//
//   Ports
//     clk         system clock, rising edge
//     reset       asynchronous, active-low; clears all state
//     serial_in   serial data bit
//     bit_valid   serial_in is consumed only when high; low cycles stall
//     abort       synchronous frame discard, has priority over bit_valid
//     load        one-cycle write strobe to the register bank
//     reg_select  address of the last good frame (held between frames)
//     data_in     data of the last good frame (held between frames)
//     busy        high whenever a frame is in progress
//     frame_err   one-cycle pulse on a bad stop or parity bit
//     frame_count number of good frames, wraps 255 -> 0
module serial_reg_loader #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              serial_in,
    input  logic              bit_valid,
    input  logic              abort,
    output logic              load,
    output logic [ADDR_W-1:0] reg_select,
    output logic [DATA_W-1:0] data_in,
    output logic              busy,
    output logic              frame_err,
    output logic [7:0]        frame_count
);

    localparam int CNT_W = $clog2((DATA_W > ADDR_W) ? DATA_W : ADDR_W);
    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_sh_q, addr_sh_d;
    logic [DATA_W-1:0] data_sh_q, data_sh_d;
    logic              parity_ok_q, parity_ok_d;
    logic              load_q, load_d;
    logic              frame_err_q, frame_err_d;
    logic [ADDR_W-1:0] reg_select_q, reg_select_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic [7:0]        frame_count_q, frame_count_d;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        addr_sh_d     = addr_sh_q;
        data_sh_d     = data_sh_q;
        parity_ok_d   = parity_ok_q;
        load_d        = 1'b0;
        frame_err_d   = 1'b0;
        reg_select_d  = reg_select_q;
        data_in_d     = data_in_q;
        frame_count_d = frame_count_q;

        if (abort) begin
            // Drop the partial frame silently; outputs keep their values.
            state_d = IDLE;
            cnt_d   = '0;
        end else if (bit_valid) begin
            unique case (state_q)
                IDLE: begin
                    // A 1 in IDLE is line idle, only a 0 starts a frame.
                    // Without the parity bit the check is always satisfied.
                    if (!serial_in) begin
                        state_d     = ADDR;
                        cnt_d       = '0;
                        parity_ok_d = 1'b1;
                    end
                end
                ADDR: begin
                    addr_sh_d = {addr_sh_q[ADDR_W-2:0], serial_in};
                    if (cnt_q == ADDR_LAST) begin
                        state_d = DATA;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                DATA: begin
                    data_sh_d = {data_sh_q[DATA_W-2:0], serial_in};
                    if (cnt_q == DATA_LAST) begin
                        cnt_d = '0;
`ifdef SERIAL_REG_LOADER_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef SERIAL_REG_LOADER_PARITY_EN
                PARITY: begin
                    // Even parity over address, data and the parity bit.
                    parity_ok_d = ~((^addr_sh_q) ^ (^data_sh_q) ^ serial_in);
                    state_d     = STOP;
                end
`endif
                STOP: begin
                    state_d = IDLE;
                    if (serial_in && parity_ok_q) begin
                        load_d        = 1'b1;
                        reg_select_d  = addr_sh_q;
                        data_in_d     = data_sh_q;
                        frame_count_d = frame_count_q + 8'd1;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            addr_sh_q     <= '0;
            data_sh_q     <= '0;
            parity_ok_q   <= 1'b0;
            load_q        <= 1'b0;
            frame_err_q   <= 1'b0;
            reg_select_q  <= '0;
            data_in_q     <= '0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            addr_sh_q     <= addr_sh_d;
            data_sh_q     <= data_sh_d;
            parity_ok_q   <= parity_ok_d;
            load_q        <= load_d;
            frame_err_q   <= frame_err_d;
            reg_select_q  <= reg_select_d;
            data_in_q     <= data_in_d;
            frame_count_q <= frame_count_d;
        end
    end

    assign load        = load_q;
    assign frame_err   = frame_err_q;
    assign reg_select  = reg_select_q;
    assign data_in     = data_in_q;
    assign frame_count = frame_count_q;
    assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_serial_reg_loader.sv
// Testbench for serial_reg_loader: randomized frames checked against a
// frame-level reference model (expected bank contents and good-frame count).
module tb_serial_reg_loader;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;
`ifdef SERIAL_REG_LOADER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              serial_in = 1'b1;
    logic              bit_valid = 1'b0;
    logic              abort = 1'b0;
    logic              load;
    logic [ADDR_W-1:0] reg_select;
    logic [DATA_W-1:0] data_in;
    logic              busy;
    logic              frame_err;
    logic [7:0]        frame_count;

    serial_reg_loader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .serial_in  (serial_in),
        .bit_valid  (bit_valid),
        .abort      (abort),
        .load       (load),
        .reg_select (reg_select),
        .data_in    (data_in),
        .busy       (busy),
        .frame_err  (frame_err),
        .frame_count(frame_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int n_load = 0;
    int n_err = 0;
    int n_both = 0;

    // Reference model: what the bank-facing outputs should hold.
    logic [ADDR_W-1:0] exp_sel = '0;
    logic [DATA_W-1:0] exp_data = '0;
    logic [7:0]        exp_cnt = '0;

    function automatic logic good_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                                        input logic par, input logic stop);
        logic par_ok;
        par_ok = !PAR_EN || (par == ((^a) ^ (^d)));
        return stop && par_ok;
    endfunction

    task automatic model_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                               input logic par, input logic stop, output logic good);
        good = good_frame(a, d, par, stop);
        if (good) begin
            exp_sel  = a;
            exp_data = d;
            exp_cnt  = exp_cnt + 8'd1;
        end
    endtask

    task automatic tick(input logic v, input logic b);
        bit_valid = v;
        serial_in = b;
        @(posedge clk);
        #1;
        if (load) n_load++;
        if (frame_err) n_err++;
        if (load && frame_err) n_both++;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 1'($urandom));
    endtask

    // Sends the first nbits bits of a frame; outputs are sampled right
    // after the edge that consumed the last bit sent.
    task automatic send_frame(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                              input logic par, input logic stop, input bit gaps,
                              input int nbits, output logic o_load, output logic o_err);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = ADDR_W - 1; i >= 0; i--) fb.push_back(a[i]);
        for (int i = DATA_W - 1; i >= 0; i--) fb.push_back(d[i]);
        if (PAR_EN) fb.push_back(par);
        fb.push_back(stop);
        for (int i = 0; i < fb.size() && i < nbits; i++) begin
            if (gaps) begin
                for (int g = 0; g < 4 && $urandom_range(1, 0) == 1; g++)
                    tick(1'b0, 1'($urandom));
            end
            tick(1'b1, fb[i]);
        end
        o_load = load;
        o_err  = frame_err;
    endtask

    task automatic test_reset();
        #2 reset = 1'b0;
        #2;
        if ({load, frame_err, busy} !== 3'b000) begin
            $display("FAIL reset_ctrl: load/err/busy=%b want 000", {load, frame_err, busy});
        end else n_pass++;
        n_total++;
        if ({reg_select, data_in, frame_count} !== '0) begin
            $display("FAIL reset_data: sel=%h data=%h cnt=%0d want 0", reg_select, data_in, frame_count);
        end else n_pass++;
        n_total++;
        @(negedge clk);
        reset = 1'b1;
        begin
            logic seen_busy;
            seen_busy = 1'b0;
            for (int i = 0; i < 10; i++) begin
                tick(1'b1, 1'b1);
                if (busy) seen_busy = 1'b1;
            end
            if (seen_busy !== 1'b0 || n_load != 0) begin
                $display("FAIL idle_ones: busy_seen=%b loads=%0d want 0,0", seen_busy, n_load);
            end else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_good_frame();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic p, g, ol, oe;
        a = 6'h05;
        d = 32'hDEADBEEF;
        p = (^a) ^ (^d);
        model_frame(a, d, p, 1'b1, g);
        send_frame(a, d, p, 1'b1, 1'b0, 999, ol, oe);
        if (ol !== g || oe !== 1'b0) begin
            $display("FAIL good_latency: load=%b err=%b want %b,0", ol, oe, g);
        end else n_pass++;
        n_total++;
        if (reg_select !== exp_sel || data_in !== exp_data) begin
            $display("FAIL good_regs: sel=%h data=%h want %h %h", reg_select, data_in, exp_sel, exp_data);
        end else n_pass++;
        n_total++;
        if (frame_count !== exp_cnt) begin
            $display("FAIL good_count: cnt=%0d want %0d", frame_count, exp_cnt);
        end else n_pass++;
        n_total++;
        tick(1'b0, 1'b1);
        if (load !== 1'b0 || busy !== 1'b0) begin
            $display("FAIL good_pulse_width: load=%b busy=%b want 0,0", load, busy);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_bad_stop();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic p, g, ol, oe;
        a = 6'h05;
        d = 32'hDEADBEEF;
        p = (^a) ^ (^d);
        model_frame(a, d, p, 1'b0, g);
        send_frame(a, d, p, 1'b0, 1'b0, 999, ol, oe);
        if (ol !== g || oe !== !g) begin
            $display("FAIL bad_stop_flags: load=%b err=%b want %b,%b", ol, oe, g, !g);
        end else n_pass++;
        n_total++;
        if (reg_select !== exp_sel || data_in !== exp_data || frame_count !== exp_cnt) begin
            $display("FAIL bad_stop_hold: sel=%h data=%h cnt=%0d want %h %h %0d",
                     reg_select, data_in, frame_count, exp_sel, exp_data, exp_cnt);
        end else n_pass++;
        n_total++;
        tick(1'b0, 1'b1);
        if (frame_err !== 1'b0) begin
            $display("FAIL bad_stop_pulse_width: err=%b want 0", frame_err);
        end else n_pass++;
        n_total++;
    endtask

`ifdef SERIAL_REG_LOADER_PARITY_EN
    task automatic test_parity();
        logic g, ol, oe;
        model_frame(6'h3F, 32'h00000001, 1'b0, 1'b1, g);
        send_frame(6'h3F, 32'h00000001, 1'b0, 1'b1, 1'b0, 999, ol, oe);
        if (ol !== g || oe !== !g) begin
            $display("FAIL parity_bad: load=%b err=%b want %b,%b", ol, oe, g, !g);
        end else n_pass++;
        n_total++;
        model_frame(6'h3F, 32'h00000001, 1'b1, 1'b1, g);
        send_frame(6'h3F, 32'h00000001, 1'b1, 1'b1, 1'b0, 999, ol, oe);
        if (ol !== g || oe !== !g || reg_select !== exp_sel || data_in !== exp_data) begin
            $display("FAIL parity_good: load=%b err=%b sel=%h data=%h want %b,%b %h %h",
                     ol, oe, reg_select, data_in, g, !g, exp_sel, exp_data);
        end else n_pass++;
        n_total++;
    endtask
`endif

    task automatic test_gaps();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic p, s, g, ol, oe;
        for (int f = 0; f < 7; f++) begin
            if (f == 0) begin
                a = 6'h12;
                d = 32'hA5A5A5A5;
                p = (^a) ^ (^d);
                s = 1'b1;
            end else begin
                a = 6'($urandom);
                d = $urandom;
                p = (^a) ^ (^d) ^ ($urandom_range(3, 0) == 0);
                s = ($urandom_range(4, 0) != 0);
            end
            model_frame(a, d, p, s, g);
            send_frame(a, d, p, s, 1'b1, 999, ol, oe);
            if (ol !== g || oe !== !g) begin
                $display("FAIL gaps_flags[%0d]: load=%b err=%b want %b,%b", f, ol, oe, g, !g);
            end else n_pass++;
            n_total++;
            if (reg_select !== exp_sel || data_in !== exp_data || frame_count !== exp_cnt) begin
                $display("FAIL gaps_regs[%0d]: sel=%h data=%h cnt=%0d want %h %h %0d",
                         f, reg_select, data_in, frame_count, exp_sel, exp_data, exp_cnt);
            end else n_pass++;
            n_total++;
        end
    endtask

    task automatic test_abort();
        int l0, e0;
        logic ol, oe;
        l0 = n_load;
        e0 = n_err;
        send_frame(6'($urandom), $urandom, 1'b0, 1'b1, 1'b0, 20, ol, oe);
        abort = 1'b1;
        tick(1'b1, 1'($urandom));
        abort = 1'b0;
        if (busy !== 1'b0) begin
            $display("FAIL abort_idle: busy=%b want 0", busy);
        end else n_pass++;
        n_total++;
        idle_cycles(3);
        if (n_load != l0 || n_err != e0) begin
            $display("FAIL abort_no_pulse: loads=%0d errs=%0d want %0d %0d", n_load, n_err, l0, e0);
        end else n_pass++;
        n_total++;
        if (reg_select !== exp_sel || data_in !== exp_data || frame_count !== exp_cnt) begin
            $display("FAIL abort_hold: sel=%h data=%h cnt=%0d want %h %h %0d",
                     reg_select, data_in, frame_count, exp_sel, exp_data, exp_cnt);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_reset_mid();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic p, g, ol, oe;
        send_frame(6'($urandom), $urandom, 1'b0, 1'b1, 1'b0, 15, ol, oe);
        bit_valid = 1'b0;
        #2 reset = 1'b0;
        #1;
        exp_sel  = '0;
        exp_data = '0;
        exp_cnt  = '0;
        if ({reg_select, data_in, frame_count} !== {exp_sel, exp_data, exp_cnt} ||
            {load, frame_err, busy} !== 3'b000) begin
            $display("FAIL reset_mid_clear: sel=%h data=%h cnt=%0d l/e/b=%b want 0",
                     reg_select, data_in, frame_count, {load, frame_err, busy});
        end else n_pass++;
        n_total++;
        @(negedge clk);
        reset = 1'b1;
        a = 6'($urandom);
        d = $urandom;
        p = (^a) ^ (^d);
        model_frame(a, d, p, 1'b1, g);
        send_frame(a, d, p, 1'b1, 1'b0, 999, ol, oe);
        if (ol !== g || frame_count !== exp_cnt || data_in !== exp_data) begin
            $display("FAIL reset_mid_recover: load=%b cnt=%0d data=%h want %b %0d %h",
                     ol, frame_count, data_in, g, exp_cnt, exp_data);
        end else n_pass++;
        n_total++;
    endtask

    task automatic test_back_to_back();
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        logic p, g, ol, oe;
        int l0, e0;
        @(negedge clk);
        bit_valid = 1'b0;
        reset = 1'b0;
        #2 reset = 1'b1;
        exp_sel  = '0;
        exp_data = '0;
        exp_cnt  = '0;
        l0 = n_load;
        e0 = n_err;
        for (int f = 0; f < 256; f++) begin
            a = 6'($urandom);
            d = $urandom;
            p = (^a) ^ (^d);
            model_frame(a, d, p, 1'b1, g);
            send_frame(a, d, p, 1'b1, 1'b0, 999, ol, oe);
        end
        if (ol !== 1'b1) begin
            $display("FAIL b2b_last_load: load=%b want 1", ol);
        end else n_pass++;
        n_total++;
        tick(1'b0, 1'b1);
        if (n_load - l0 != 256 || n_err != e0) begin
            $display("FAIL b2b_pulses: loads=%0d errs=%0d want 256 0", n_load - l0, n_err - e0);
        end else n_pass++;
        n_total++;
        if (frame_count !== exp_cnt) begin
            $display("FAIL b2b_wrap: cnt=%0d want %0d", frame_count, exp_cnt);
        end else n_pass++;
        n_total++;
        if (reg_select !== exp_sel || data_in !== exp_data) begin
            $display("FAIL b2b_regs: sel=%h data=%h want %h %h", reg_select, data_in, exp_sel, exp_data);
        end else n_pass++;
        n_total++;
        if (n_both != 0) begin
            $display("FAIL load_err_overlap: cycles=%0d want 0", n_both);
        end else n_pass++;
        n_total++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_stop();
`ifdef SERIAL_REG_LOADER_PARITY_EN
        test_parity();
`endif
        test_gaps();
        test_abort();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
